// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared op codes, default widths and ID-width helper
// for the video-memory arbiter (mem_arbiter, mem_arb_tag_fifo).
package mem_arb_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_READ  = 4'b0001;
  localparam logic [3:0] OP_WRITE = 4'b0010;
  localparam logic [3:0] OP_CLEAR = 4'b1111;

  localparam int DEF_ADDR_W = 17;
  localparam int DEF_DATA_W = 32;

  // Requester ID width; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// mem_arb_tag_fifo: in-order FIFO of requester IDs for outstanding reads.
// Ports: clk, rst (async high), push/din, pop/dout, full, empty, count.
module mem_arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rp];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push)
        wp <= wp + PW'(1);
      if (do_pop)
        rp <= rp + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of the video-memory port among NUM_REQ
// requesters. Ports: req_* (rts/rtr bundles, flat-packed per requester),
// mem_* (registered one-deep slice toward memory, read return inputs),
// rd_valid/rd_data (one-hot read return), rd_err (sticky orphan return).
// Optional MEM_ARB_BURST_LOCK_EN: hold the grant on one requester for up
// to BURST_MAX transfers while it keeps requesting.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TAG_DEPTH = 4,
  parameter int BURST_MAX = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_rts,
  output logic [NUM_REQ-1:0]        req_rtr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wr_data,
  input  logic [NUM_REQ*4-1:0]      req_op,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wr_data,
  output logic [3:0]                mem_op,
  output logic                      mem_rts,
  input  logic                      mem_rtr,
  input  logic                      mem_rd_valid,
  input  logic [DATA_W-1:0]         mem_rd_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_err
);

  localparam int ID_W = id_w(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win;
  logic [ID_W-1:0]  idx;
  logic             found;
  logic [NUM_REQ-1:0] elig;
  logic             can_accept;
  logic             xfer;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [3:0]        w_op;

  logic [ID_W-1:0]           tag_dout;
  logic                      tag_full;
  logic                      tag_empty;
  logic [$clog2(TAG_DEPTH):0] tag_count;
  logic                      read_blocked;

`ifdef MEM_ARB_BURST_LOCK_EN
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  logic             lock_valid;
  logic [ID_W-1:0]  lock_id;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] cnt_next;
`endif

  function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] v);
    return ID_W'((int'(v) + 1) % NUM_REQ);
  endfunction

  // A pop in this cycle deliberately does not free a read slot.
  assign read_blocked = (int'(tag_count) == TAG_DEPTH);
  assign can_accept   = !mem_rts || mem_rtr;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_rts[i] &&
                !(req_op[i*4 +: 4] == OP_READ && read_blocked);
  end

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
`ifdef MEM_ARB_BURST_LOCK_EN
    if (lock_valid && elig[lock_id]) begin
      found = 1'b1;
      win   = lock_id;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign req_rtr = (found && can_accept && !rst) ? (ONE << win) : '0;
  assign xfer    = |req_rtr;

  assign w_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
  assign w_data = req_wr_data[int'(win)*DATA_W +: DATA_W];
  assign w_op   = req_op[int'(win)*4 +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rts     <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_op      <= '0;
    end else if (xfer) begin
      mem_rts     <= 1'b1;
      mem_addr    <= w_addr;
      mem_wr_data <= (w_op == OP_CLEAR) ? '0 : w_data;
      mem_op      <= w_op;
    end else if (mem_rtr) begin
      mem_rts     <= 1'b0;
    end
  end

`ifdef MEM_ARB_BURST_LOCK_EN
  assign cnt_next = (lock_valid && win == lock_id) ?
                    burst_cnt + CNT_W'(1) : CNT_W'(1);

  // Pointer moves only when the lock releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      lock_valid <= 1'b0;
      lock_id    <= '0;
      burst_cnt  <= '0;
    end else if (xfer) begin
      if (int'(cnt_next) >= BURST_MAX) begin
        lock_valid <= 1'b0;
        burst_cnt  <= '0;
        ptr        <= inc_id(win);
      end else begin
        lock_valid <= 1'b1;
        lock_id    <= win;
        burst_cnt  <= cnt_next;
      end
    end else if (lock_valid && !req_rts[lock_id]) begin
      lock_valid <= 1'b0;
      burst_cnt  <= '0;
      ptr        <= inc_id(lock_id);
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (xfer)
      ptr <= inc_id(win);
  end
`endif

  mem_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (ID_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (xfer && w_op == OP_READ && !tag_full),
    .pop   (mem_rd_valid),
    .din   (win),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign rd_data  = mem_rd_data;
  assign rd_valid = (mem_rd_valid && !tag_empty && !rst) ?
                    (ONE << tag_dout) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_err <= 1'b0;
    else if (mem_rd_valid && tag_empty)
      rd_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks with queue-based expected values
// for mem_arbiter (default parameters).
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 17;
  localparam int DW = 32;
`ifdef MEM_ARB_BURST_LOCK_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_rts = '0;
  logic [N-1:0]    req_rtr;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wr_data = '0;
  logic [N*4-1:0]  req_op = '0;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wr_data;
  logic [3:0]      mem_op;
  logic            mem_rts;
  logic            mem_rtr = 1'b0;
  logic            mem_rd_valid = 1'b0;
  logic [DW-1:0]   mem_rd_data = '0;
  logic [N-1:0]    rd_valid;
  logic [DW-1:0]   rd_data;
  logic            rd_err;

  int checks = 0;
  int errors = 0;
  int          exp_addr_q[$];
  int          exp_id_q[$];
  logic [31:0] exp_data_q[$];

  mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_rts      (req_rts),
    .req_rtr      (req_rtr),
    .req_addr     (req_addr),
    .req_wr_data  (req_wr_data),
    .req_op       (req_op),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_op       (mem_op),
    .mem_rts      (mem_rts),
    .mem_rtr      (mem_rtr),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_err       (rd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic set_req(input int i, input logic rts,
                         input logic [AW-1:0] a, input logic [3:0] op,
                         input logic [DW-1:0] d);
    req_rts[i]            = rts;
    req_addr[i*AW +: AW]  = a;
    req_op[i*4 +: 4]      = op;
    req_wr_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    req_rts      = '0;
    mem_rtr      = 1'b0;
    mem_rd_valid = 1'b0;
    exp_addr_q.delete();
    exp_id_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_rts = 4'hF;
    #3;
    checks++;
    if (mem_rts !== 1'b0 || mem_addr !== '0 || mem_op !== 4'h0 ||
        mem_wr_data !== '0) begin
      errors++;
      $display("FAIL reset_slice: rts=%b addr=%h op=%h data=%h required 0",
               mem_rts, mem_addr, mem_op, mem_wr_data);
    end
    checks++;
    if (req_rtr !== 4'b0000) begin
      errors++;
      $display("FAIL reset_rtr: got %b required 0000", req_rtr);
    end
    checks++;
    if (rd_valid !== 4'b0000 || rd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd: rd_valid=%b rd_err=%b required 0",
               rd_valid, rd_err);
    end
    req_rts = '0;
  endtask

  task automatic test_round_robin();
    int g;
    int e;
    do_reset();
    mem_rtr = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0)
        for (int i = 0; i < N; i++)
          set_req(i, 1'b1, AW'(i), 4'b0010, 32'h100 + i);
      #1;
      g = BURST ? 0 : c % N;
      checks++;
      if (req_rtr !== (4'b0001 << g)) begin
        errors++;
        $display("FAIL rr_grant c=%0d: got %b required %b",
                 c, req_rtr, 4'b0001 << g);
      end
      checks++;
      if (c == 0) begin
        if (mem_rts !== 1'b0) begin
          errors++;
          $display("FAIL rr_first_rts: got %b required 0", mem_rts);
        end
      end else begin
        e = exp_addr_q.pop_front();
        if (mem_rts !== 1'b1 || mem_addr !== AW'(e)) begin
          errors++;
          $display("FAIL rr_addr c=%0d: rts=%b addr=%0d required 1/%0d",
                   c, mem_rts, mem_addr, e);
        end
      end
      exp_addr_q.push_back(g);
    end
    @(negedge clk);
    req_rts = '0;
    #1;
    e = exp_addr_q.pop_front();
    checks++;
    if (mem_rts !== 1'b1 || mem_addr !== AW'(e)) begin
      errors++;
      $display("FAIL rr_last: rts=%b addr=%0d required 1/%0d",
               mem_rts, mem_addr, e);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mem_rts !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain: got %b required 0", mem_rts);
    end
  endtask

  task automatic test_clear_op();
    do_reset();
    mem_rtr = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 17'd7, 4'b1111, 32'hFFFF_FFFF);
    @(negedge clk);
    set_req(0, 1'b1, 17'd8, 4'b0101, 32'h1234_5678);
    #1;
    checks++;
    if (mem_op !== 4'hF || mem_wr_data !== 32'h0 || mem_addr !== 17'd7) begin
      errors++;
      $display("FAIL clear_op: op=%h data=%h addr=%0d required f/0/7",
               mem_op, mem_wr_data, mem_addr);
    end
    @(negedge clk);
    req_rts = '0;
    #1;
    checks++;
    if (mem_op !== 4'h5 || mem_wr_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL other_op: op=%h data=%h required 5/12345678",
               mem_op, mem_wr_data);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    set_req(2, 1'b1, 17'd5, 4'b0010, 32'hA5);
    #1;
    checks++;
    if (req_rtr !== 4'b0100) begin
      errors++;
      $display("FAIL bp_first: got %b required 0100", req_rtr);
    end
    @(negedge clk);
    set_req(2, 1'b1, 17'd6, 4'b0010, 32'hA6);
    for (int k = 0; k < 5; k++) begin
      if (k > 0)
        @(negedge clk);
      #1;
      checks++;
      if (mem_rts !== 1'b1 || mem_addr !== 17'd5 || mem_op !== 4'h2 ||
          req_rtr !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold k=%0d: rts=%b addr=%0d op=%h rtr=%b", k,
                 mem_rts, mem_addr, mem_op, req_rtr);
      end
    end
    @(negedge clk);
    mem_rtr = 1'b1;
    #1;
    checks++;
    if (req_rtr !== 4'b0100 || mem_addr !== 17'd5) begin
      errors++;
      $display("FAIL bp_release: rtr=%b addr=%0d required 0100/5",
               req_rtr, mem_addr);
    end
    @(negedge clk);
    req_rts = '0;
    #1;
    checks++;
    if (mem_rts !== 1'b1 || mem_addr !== 17'd6) begin
      errors++;
      $display("FAIL bp_next: rts=%b addr=%0d required 1/6",
               mem_rts, mem_addr);
    end
  endtask

  task automatic test_read_full();
    int id;
    do_reset();
    mem_rtr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_req(1, 1'b1, AW'(10 + k), 4'b0001, '0);
      #1;
      checks++;
      if (k < 4) begin
        if (req_rtr !== 4'b0010) begin
          errors++;
          $display("FAIL rdfull_accept k=%0d: got %b required 0010",
                   k, req_rtr);
        end
        exp_id_q.push_back(1);
      end else if (req_rtr !== 4'b0000) begin
        errors++;
        $display("FAIL rdfull_block: got %b required 0000", req_rtr);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_rtr !== 4'b0000) begin
      errors++;
      $display("FAIL rdfull_still: got %b required 0000", req_rtr);
    end
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'hDEADBEEF;
    #1;
    id = exp_id_q.pop_front();
    checks++;
    if (rd_valid !== (4'b0001 << id) || rd_data !== 32'hDEADBEEF ||
        req_rtr !== 4'b0000) begin
      errors++;
      $display("FAIL rdfull_return: rd_valid=%b data=%h rtr=%b", rd_valid,
               rd_data, req_rtr);
    end
    @(negedge clk);
    mem_rd_valid = 1'b0;
    #1;
    checks++;
    if (req_rtr !== 4'b0010) begin
      errors++;
      $display("FAIL rdfull_unblock: got %b required 0010", req_rtr);
    end
    @(negedge clk);
    req_rts = '0;
  endtask

  task automatic test_interleave();
    int id;
    logic [31:0] d;
    do_reset();
    mem_rtr = 1'b1;
    @(negedge clk);
    set_req(3, 1'b1, 17'd30, 4'b0001, '0);
    #1;
    checks++;
    if (req_rtr !== 4'b1000) begin
      errors++;
      $display("FAIL il_grant3: got %b required 1000", req_rtr);
    end
    exp_id_q.push_back(3);
    exp_data_q.push_back(32'hAAAA_0003);
    @(negedge clk);
    req_rts = '0;
    set_req(0, 1'b1, 17'd40, 4'b0001, '0);
    #1;
    checks++;
    if (req_rtr !== 4'b0001) begin
      errors++;
      $display("FAIL il_grant0: got %b required 0001", req_rtr);
    end
    exp_id_q.push_back(0);
    exp_data_q.push_back(32'hBBBB_0000);
    @(negedge clk);
    req_rts = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      d  = exp_data_q.pop_front();
      id = exp_id_q.pop_front();
      mem_rd_valid = 1'b1;
      mem_rd_data  = d;
      #1;
      checks++;
      if (rd_valid !== (4'b0001 << id) || rd_data !== d) begin
        errors++;
        $display("FAIL il_return k=%0d: rd_valid=%b data=%h required %b/%h",
                 k, rd_valid, rd_data, 4'b0001 << id, d);
      end
    end
    @(negedge clk);
    mem_rd_valid = 1'b0;
    #1;
    checks++;
    if (rd_err !== 1'b0) begin
      errors++;
      $display("FAIL il_no_err: got %b required 0", rd_err);
    end
  endtask

  task automatic test_rd_err_and_mid_reset();
    do_reset();
    @(negedge clk);
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'h1;
    #1;
    checks++;
    if (rd_valid !== 4'b0000) begin
      errors++;
      $display("FAIL err_no_valid: got %b required 0000", rd_valid);
    end
    @(negedge clk);
    mem_rd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (rd_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b required 1", rd_err);
    end
    mem_rtr = 1'b1;
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, AW'(16'h100 + i), 4'b0010, 32'h55 + i);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_rts !== 1'b0 || mem_addr !== '0 || mem_wr_data !== '0 ||
        mem_op !== 4'h0 || req_rtr !== 4'b0000 || rd_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: rts=%b addr=%h data=%h op=%h rtr=%b err=%b",
               mem_rts, mem_addr, mem_wr_data, mem_op, req_rtr, rd_err);
    end
    req_rts = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_burst();
    int g;
    int n;
    do_reset();
    mem_rtr = 1'b1;
    n = BURST ? 32 : 8;
    @(negedge clk);
    set_req(0, 1'b1, 17'd0, 4'b0010, '0);
    set_req(1, 1'b1, 17'd1, 4'b0010, '0);
    for (int c = 0; c < n; c++) begin
      if (c > 0)
        @(negedge clk);
      #1;
      g = BURST ? ((c < 16) ? 0 : 1) : (c % 2);
      checks++;
      if (req_rtr !== (4'b0001 << g)) begin
        errors++;
        $display("FAIL burst c=%0d: got %b required %b",
                 c, req_rtr, 4'b0001 << g);
      end
    end
    @(negedge clk);
    req_rts = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_clear_op();
    test_backpressure();
    test_read_full();
    test_interleave();
    test_rd_err_and_mid_reset();
    test_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
